// File: rtl/riscv_defines.sv
// Shared definitions for the DIFT tag-violation controller: FSM encoding and
// bit positions of the violation cause vector.
package riscv_defines;

    typedef enum logic [1:0] {
        TV_IDLE   = 2'd0,
        TV_REPORT = 2'd1,
        TV_DRAIN  = 2'd2
    } tv_state_e;

    localparam int CAUSE_S1 = 0;
    localparam int CAUSE_S2 = 1;
    localparam int CAUSE_D  = 2;

endpackage

// File: rtl/riscv_tag_sat_counter.sv
// Saturating event counter; a clear wins over the hold value but still counts
// an event arriving in the same cycle.
module riscv_tag_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_clr) begin
            w_count_next = i_inc ? CNT_WIDTH'(1) : '0;
        end else if (i_inc && !(&r_count)) begin
            w_count_next = r_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/riscv_tag_violation_ctrl.sv
// DIFT tag-violation controller: detects tagged operands on the ID->EX hand-off,
// captures the offending instruction and holds the pipeline until the trap is taken.
module riscv_tag_violation_ctrl
    import riscv_defines::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic                 id_valid_i,
    input  logic                 check_s1_i,
    input  logic                 check_s2_i,
    input  logic                 check_d_i,
    input  logic                 tag_rs1_i,
    input  logic                 tag_rs2_i,
    input  logic                 tag_rd_i,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          instr_i,
    input  logic                 trap_ack_i,
    input  logic                 cnt_clear_i,
    output logic                 trap_req_o,
    output logic                 stall_o,
    output logic [2:0]           trap_cause_o,
    output logic [31:0]          trap_pc_o,
    output logic [31:0]          trap_instr_o,
    output logic [CNT_WIDTH-1:0] viol_cnt_o
);

    tv_state_e   r_state;
    tv_state_e   w_state_next;
    logic [2:0]  w_cause;
    logic        w_detect;
    logic [2:0]  r_cause;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    assign w_cause[CAUSE_S1] = check_s1_i & tag_rs1_i;
    assign w_cause[CAUSE_S2] = check_s2_i & tag_rs2_i;
    assign w_cause[CAUSE_D]  = check_d_i  & tag_rd_i;

    // Gating with rst_n keeps stall low while reset is held, even with violating inputs.
    assign w_detect = rst_n & enable_i & id_valid_i & (r_state == TV_IDLE) & (|w_cause);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            TV_IDLE:   if (w_detect)   w_state_next = TV_REPORT;
            TV_REPORT: if (trap_ack_i) w_state_next = TV_DRAIN;
            TV_DRAIN:  w_state_next = TV_IDLE;
            default:   w_state_next = TV_IDLE;
        endcase
    end

    // Capture registers only load on a fresh detect so they stay stable across REPORT/DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cause <= '0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (w_detect) begin
            r_cause <= w_cause;
            r_pc    <= pc_i;
            r_instr <= instr_i;
        end
    end

    riscv_tag_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_viol_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_detect),
        .i_clr   (cnt_clear_i),
        .o_count (viol_cnt_o)
    );

    assign trap_req_o   = (r_state == TV_REPORT);
    assign stall_o      = w_detect | (r_state == TV_REPORT) | (r_state == TV_DRAIN);
    assign trap_cause_o = r_cause;
    assign trap_pc_o    = r_pc;
    assign trap_instr_o = r_instr;

endmodule

// File: tb/tb_riscv_tag_violation_ctrl.sv
// Self-checking bench for riscv_tag_violation_ctrl: directed scenarios plus
// randomized traffic against a behavioural model of the trap protocol.
module tb_riscv_tag_violation_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable_i, id_valid_i;
    logic          check_s1_i, check_s2_i, check_d_i;
    logic          tag_rs1_i, tag_rs2_i, tag_rd_i;
    logic [31:0]   pc_i, instr_i;
    logic          trap_ack_i, cnt_clear_i;
    logic          trap_req_o, stall_o;
    logic [2:0]    trap_cause_o;
    logic [31:0]   trap_pc_o, trap_instr_o;
    logic [CW-1:0] viol_cnt_o;

    always #5 clk = ~clk;

    riscv_tag_violation_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .id_valid_i   (id_valid_i),
        .check_s1_i   (check_s1_i),
        .check_s2_i   (check_s2_i),
        .check_d_i    (check_d_i),
        .tag_rs1_i    (tag_rs1_i),
        .tag_rs2_i    (tag_rs2_i),
        .tag_rd_i     (tag_rd_i),
        .pc_i         (pc_i),
        .instr_i      (instr_i),
        .trap_ack_i   (trap_ack_i),
        .cnt_clear_i  (cnt_clear_i),
        .trap_req_o   (trap_req_o),
        .stall_o      (stall_o),
        .trap_cause_o (trap_cause_o),
        .trap_pc_o    (trap_pc_o),
        .trap_instr_o (trap_instr_o),
        .viol_cnt_o   (viol_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: a trap is either absent, pending (waiting for ack), or draining for one cycle.
    bit          m_pending;
    bit          m_draining;
    logic [2:0]  m_cause;
    logic [31:0] m_pc, m_instr;
    int          m_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_viol_bits();
        return {check_d_i & tag_rd_i, check_s2_i & tag_rs2_i, check_s1_i & tag_rs1_i};
    endfunction

    function automatic bit m_detect();
        return enable_i && id_valid_i && !m_pending && !m_draining && (m_viol_bits() != 3'b000);
    endfunction

    task automatic model_reset();
        m_pending = 0; m_draining = 0; m_cause = '0; m_pc = '0; m_instr = '0; m_cnt = 0;
    endtask

    task automatic quiet_inputs();
        id_valid_i = 0; check_s1_i = 0; check_s2_i = 0; check_d_i = 0;
        tag_rs1_i = 0; tag_rs2_i = 0; tag_rd_i = 0;
        trap_ack_i = 0; cnt_clear_i = 0; pc_i = '0; instr_i = '0;
    endtask

    task automatic set_viol(input logic s1, input logic s2, input logic d, input logic [31:0] pc);
        id_valid_i = 1;
        check_s1_i = s1; tag_rs1_i = s1;
        check_s2_i = s2; tag_rs2_i = s2;
        check_d_i  = d;  tag_rd_i  = d;
        pc_i = pc; instr_i = $urandom;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        bit det;
        #3;
        det = m_detect();
        check_val("stall", stall_o, det || m_pending || m_draining);
        @(posedge clk);
        if (cnt_clear_i)  m_cnt = det ? 1 : 0;
        else if (det)     m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (det) begin
            m_cause = m_viol_bits(); m_pc = pc_i; m_instr = instr_i;
            m_pending = 1;
        end else if (m_pending && trap_ack_i) begin
            m_pending = 0; m_draining = 1;
        end else if (m_draining) begin
            m_draining = 0;
        end
        #1;
        check_val("trap_req", trap_req_o, m_pending);
        check_val("cause", trap_cause_o, m_cause);
        check_val("trap_pc", trap_pc_o, m_pc);
        check_val("trap_instr", trap_instr_o, m_instr);
        check_val("viol_cnt", viol_cnt_o, m_cnt);
    endtask

    task automatic take_trap();
        quiet_inputs(); trap_ack_i = 1; cycle();
        trap_ack_i = 0; cycle();
    endtask

    initial begin
        rst_n = 0; enable_i = 1;
        quiet_inputs();
        model_reset();
        set_viol(1, 1, 1, 32'h44);
        #2;
        check_val("rst_stall", stall_o, 1'b0);
        check_val("rst_trap_req", trap_req_o, 1'b0);
        check_val("rst_cnt", viol_cnt_o, 0);
        check_val("rst_cause", trap_cause_o, 0);
        quiet_inputs();
        #20 rst_n = 1;
        @(posedge clk); #1;

        // Single rs1 violation
        set_viol(1, 0, 0, 32'h80);
        cycle();
        check_val("d018_cause", trap_cause_o, 3'b001);
        check_val("d018_pc", trap_pc_o, 32'h80);
        quiet_inputs(); cycle();
        trap_ack_i = 1; cycle();
        // Violation during DRAIN must be ignored
        trap_ack_i = 0; set_viol(0, 1, 0, 32'h90); cycle();
        quiet_inputs(); cycle();

        // Two sources, ack withheld for five cycles
        set_viol(1, 0, 1, 32'h100); cycle();
        check_val("d019_cause", trap_cause_o, 3'b101);
        quiet_inputs();
        for (int i = 0; i < 5; i++) begin
            set_viol(0, 1, 0, 32'h200 + i); cycle();
        end
        take_trap();

        // Checking disabled
        enable_i = 0;
        for (int i = 0; i < 3; i++) begin
            set_viol(1, 1, 1, 32'h300); cycle();
        end
        enable_i = 1; quiet_inputs();

        // Dropping enable while a trap is pending
        set_viol(0, 1, 0, 32'h400); cycle();
        enable_i = 0; quiet_inputs(); cycle(); cycle();
        take_trap();
        enable_i = 1;

        // Saturation then clear with simultaneous detect
        for (int i = 0; i < 17; i++) begin
            set_viol(1, 0, 0, 32'h1000 + 4 * i); cycle();
            take_trap();
        end
        check_val("d021_sat", viol_cnt_o, 4'hF);
        set_viol(0, 0, 1, 32'h2000); cnt_clear_i = 1; cycle();
        check_val("d021_clr_det", viol_cnt_o, 4'h1);
        take_trap();
        cnt_clear_i = 1; cycle(); cnt_clear_i = 0;

        // Asynchronous reset in the middle of REPORT
        set_viol(1, 1, 0, 32'h3000); cycle();
        quiet_inputs();
        #2 rst_n = 0;
        #1;
        check_val("d022_trap_req", trap_req_o, 1'b0);
        check_val("d022_stall", stall_o, 1'b0);
        check_val("d022_cnt", viol_cnt_o, 0);
        check_val("d022_pc", trap_pc_o, 0);
        model_reset();
        #6 rst_n = 1;
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            enable_i    = ($urandom_range(0, 7) != 0);
            id_valid_i  = $urandom_range(0, 1);
            check_s1_i  = $urandom_range(0, 1);
            check_s2_i  = $urandom_range(0, 1);
            check_d_i   = $urandom_range(0, 1);
            tag_rs1_i   = ($urandom_range(0, 3) == 0);
            tag_rs2_i   = ($urandom_range(0, 3) == 0);
            tag_rd_i    = ($urandom_range(0, 3) == 0);
            pc_i        = $urandom;
            instr_i     = $urandom;
            trap_ack_i  = ($urandom_range(0, 2) == 0);
            cnt_clear_i = ($urandom_range(0, 24) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
